// File: rtl/top_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : top_pkg
//  Brief    : Shared types, constants and the Hamming(16,11) SECDED encoder
//             function for the top_level encoder engine.
//  Revision : 1.0 - initial release
// ============================================================================
package top_pkg;

  // Run geometry
  localparam int unsigned NUM_MSG   = 15;
  localparam int unsigned MEM_DEPTH = 256;
  localparam logic [7:0]  SRC_BASE  = 8'd0;
  localparam logic [7:0]  DST_BASE  = 8'd30;
  localparam logic [3:0]  LAST_IDX  = 4'(NUM_MSG - 1);

  // Engine sequencing: two reads and two writes per message
  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_RD_LO = 3'd1,
    ST_RD_HI = 3'd2,
    ST_WR_HI = 3'd3,
    ST_WR_LO = 3'd4,
    ST_FIN   = 3'd5
  } state_t;

  // d[0] carries data bit d1, d[10] carries d11.
  // Result layout: {d11..d5, p8, d4, d3, d2, p4, d1, p2, p1, p0}
  function automatic logic [15:0] hamming_encode(input logic [10:0] d);
    logic p8, p4, p2, p1, p0;
    p8 = ^d[10:4];
    p4 = ^{d[10], d[9], d[8], d[7], d[3], d[2], d[1]};
    p2 = ^{d[10], d[9], d[6], d[5], d[3], d[2], d[0]};
    p1 = ^{d[10], d[8], d[6], d[4], d[3], d[1], d[0]};
    // Overall parity makes the full 16-bit word even
    p0 = ^{d, p8, p4, p2, p1};
    return {d[10:4], p8, d[3:1], p4, d[0], p2, p1, p0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/top_level_data_mem.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem
//  Brief    : Byte-wide data memory, combinational read, synchronous write.
//             Contents are deliberately not reset so preloaded data survives.
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem
  import top_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);

  logic [7:0] core [0:MEM_DEPTH-1];

  // Asynchronous read path feeds the engine's latches in the same cycle
  always_comb begin
    rdata = core[addr];
  end

  // Single write port, no reset on the array
  always_ff @(posedge clk) begin
    if (we) begin
      core[addr] <= wdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/top_level.sv
`default_nettype none
// ============================================================================
//  Module   : top_level
//  Brief    : Hamming(16,11) SECDED encoder engine. Reads NUM_MSG packed
//             11-bit messages from the data memory, writes the 16-bit
//             codewords back, then raises done until the next reset.
//  Revision : 1.0 - initial release
// ============================================================================
module top_level
  import top_pkg::*;
(
  input  logic clk,
  input  logic reset,   // synchronous, active-low
  output logic done
);

  state_t     state_q, state_d;
  logic [3:0] idx_q,   idx_d;
  logic [7:0] lo_q,    lo_d;
  logic [2:0] hi_q,    hi_d;
  logic       done_q,  done_d;

  logic        engine_we;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [7:0]  idx_x2;
  logic [15:0] codeword;

  assign idx_x2   = {3'b000, idx_q, 1'b0};
  assign codeword = hamming_encode({hi_q, lo_q});
  // A write cycle interrupted by reset must not reach the memory
  assign mem_we   = engine_we & reset;
  assign done     = done_q;

  data_mem dm1 (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // State, index, data latch and done registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_RST;
      idx_q   <= 4'd0;
      lo_q    <= 8'd0;
      hi_q    <= 3'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      done_q  <= done_d;
    end
  end

  // Next-state, address mux and write-data selection
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    engine_we = 1'b0;
    mem_addr  = 8'd0;
    mem_wdata = 8'd0;

    case (state_q)
      ST_RST: begin
        state_d = ST_RD_LO;
      end
      ST_RD_LO: begin
        mem_addr = SRC_BASE + idx_x2;
        lo_d     = mem_rdata;
        state_d  = ST_RD_HI;
      end
      ST_RD_HI: begin
        mem_addr = SRC_BASE + idx_x2 + 8'd1;
        // Only d11..d9 live in the high byte; the rest is don't-care
        hi_d     = mem_rdata[2:0];
        state_d  = ST_WR_HI;
      end
      ST_WR_HI: begin
        mem_addr  = DST_BASE + idx_x2 + 8'd1;
        mem_wdata = codeword[15:8];
        engine_we = 1'b1;
        state_d   = ST_WR_LO;
      end
      ST_WR_LO: begin
        mem_addr  = DST_BASE + idx_x2;
        mem_wdata = codeword[7:0];
        engine_we = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = ST_FIN;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = ST_RD_LO;
        end
      end
      ST_FIN: begin
        state_d = ST_FIN;
      end
      default: begin
        state_d = ST_RST;
      end
    endcase
  end

  // done is registered and rises on the same edge that enters FIN
  always_comb begin
    done_d = (state_d == ST_FIN);
  end

endmodule
`default_nettype wire

// File: tb/tb_top_level.sv
`default_nettype none
// ============================================================================
//  Module   : tb_top_level
//  Brief    : Self-checking bench for top_level. Preloads messages by
//             backdoor, runs the engine and compares every codeword and
//             every untouched byte against a positional Hamming model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_top_level;

  logic clk;
  logic reset;
  logic done;

  int n_pass;
  int n_total;

  logic [7:0] src_lo [0:14];
  logic [7:0] src_hi [0:14];
  logic [7:0] snap   [0:255];

  top_level dut (
    .clk   (clk),
    .reset (reset),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Classic Hamming layout: data fills the non-power-of-two positions 1..15,
  // each parity position p covers positions k with (k & p) != 0, bit 0 is
  // overall parity.
  function automatic logic [15:0] model_cw(input logic [10:0] d);
    logic [15:0] w;
    logic        par;
    int          k;
    w = 16'd0;
    k = 0;
    for (int pos = 1; pos < 16; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        w[pos] = d[k];
        k++;
      end
    end
    for (int p = 1; p < 16; p = p * 2) begin
      par = 1'b0;
      for (int pos = 1; pos < 16; pos++) begin
        if ((pos & p) != 0 && pos != p) par = par ^ w[pos];
      end
      w[p] = par;
    end
    w[0] = ^w[15:1];
    return w;
  endfunction

  function automatic logic [15:0] dut_word(input int i);
    return {dut.dm1.core[31 + 2*i], dut.dm1.core[30 + 2*i]};
  endfunction

  // Hold reset, load sources into memory, fill everything else with random
  // sentinel bytes and remember them.
  task automatic preload();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    for (int a = 0; a < 256; a++) begin
      if (a < 30) begin
        snap[a] = ((a % 2) == 0) ? src_lo[a/2] : src_hi[a/2];
      end else begin
        snap[a] = 8'($urandom_range(0, 255));
      end
      dut.dm1.core[a] = snap[a];
    end
    @(negedge clk);
    check("reset_done", {31'd0, done}, 32'd0);
  endtask

  // Release reset and count clocks until done, bounded
  task automatic run_and_time(input string tag);
    int n;
    n = 0;
    reset = 1'b1;
    while (n < 200 && done !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, 61);
  endtask

  task automatic verify(input string tag);
    int bad;
    for (int i = 0; i < 15; i++) begin
      check($sformatf("%s_cw%0d", tag, i), {16'd0, dut_word(i)},
            {16'd0, model_cw({src_hi[i][2:0], src_lo[i]})});
    end
    bad = 0;
    for (int a = 0; a < 256; a++) begin
      if ((a < 30 || a >= 60) && dut.dm1.core[a] !== snap[a]) bad++;
    end
    check({tag, "_untouched"}, bad, 0);
    repeat (5) @(negedge clk);
    check({tag, "_done_held"}, {31'd0, done}, 32'd1);
  endtask

  task automatic randomize_src();
    for (int i = 0; i < 15; i++) begin
      src_lo[i] = 8'($urandom_range(0, 255));
      src_hi[i] = 8'($urandom_range(0, 255));
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b0;

    // Case 1: all-zero messages
    for (int i = 0; i < 15; i++) begin
      src_lo[i] = 8'h00;
      src_hi[i] = 8'h00;
    end
    preload();
    run_and_time("zero");
    verify("zero");

    // Case 2: directed corner messages, rest random
    randomize_src();
    src_lo[0] = 8'hFF; src_hi[0] = 8'h07;
    src_lo[1] = 8'h01; src_hi[1] = 8'h00;
    src_lo[2] = 8'h00; src_hi[2] = 8'h04;
    src_lo[3] = 8'h10; src_hi[3] = 8'h00;
    src_lo[4] = 8'h00; src_hi[4] = 8'hF8;
    src_lo[5] = 8'hFF; src_hi[5] = 8'hFF;
    preload();
    run_and_time("dir");
    check("dir_all_ones", {16'd0, dut_word(0)}, 32'h0000FFFF);
    check("dir_d1_only",  {16'd0, dut_word(1)}, 32'h0000000F);
    check("dir_d11_only", {16'd0, dut_word(2)}, 32'h00008117);
    check("dir_d5_only",  {16'd0, dut_word(3)}, 32'h00000303);
    check("dir_hi_junk0", {16'd0, dut_word(4)}, 32'h00000000);
    check("dir_hi_junk1", {16'd0, dut_word(5)}, 32'h0000FFFF);
    verify("dir");

    // Case 3: fully random runs
    for (int r = 0; r < 3; r++) begin
      randomize_src();
      preload();
      run_and_time($sformatf("rnd%0d", r));
      verify($sformatf("rnd%0d", r));
    end

    // Case 4: one-cycle reset pulse 20 clocks into a run
    randomize_src();
    preload();
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("mid_done_before", {31'd0, done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("mid_done_in_reset", {31'd0, done}, 32'd0);
    run_and_time("mid");
    verify("mid");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
